// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, stall
// vector encodings, redirect constants and the stall priority decode.
package pipe_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } pipe_state_t;

  // Stall vectors are contiguous ones from bit 0; bit 5 (WB) is never set.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;
  localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;
  localparam logic        RST_ENABLE     = 1'b1;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  function automatic logic [5:0] stall_prio(input logic req_if,
                                            input logic req_id,
                                            input logic req_ex,
                                            input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stall requests and MEM exceptions into the
// stall vector, flush pulse and redirect PC, and drains a fetch after a flush.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue; stall requests and exceptions are decoded
// ST_DRAIN | post-flush; hold PC/IF and discard the outstanding fetch
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             ibus_busy_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             fetch_discard,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t state, state_nxt;
  logic        exc_pending;

  assign exc_pending = (excepttype_i != ZERO_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall[0]) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced to zero while rst is high so reset takes effect
  // immediately, independent of whatever the stages are requesting.
  always_comb begin
    state_nxt     = state;
    stall         = STALL_NONE;
    flush         = 1'b0;
    new_pc        = ZERO_WORD;
    fetch_discard = 1'b0;
    if (rst != RST_ENABLE) begin
      unique case (state)
        ST_RUN: begin
          if (exc_pending && !stallreq_mem) begin
            flush     = 1'b1;
            new_pc    = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
            state_nxt = ibus_busy_i ? ST_DRAIN : ST_RUN;
          end else begin
            // A pending exception behind a MEM stall falls out as STALL_MEM.
            stall = stall_prio(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
          end
        end
        ST_DRAIN: begin
          stall         = STALL_IF;
          fetch_discard = 1'b1;
          if (!ibus_busy_i) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, exception/eret redirect,
// fetch drain, deferred exception, counter wrap and async reset mid-drain.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0]      excepttype_i, cp0_epc_i;
  logic             ibus_busy_i;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic             fetch_discard;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .ibus_busy_i  (ibus_busy_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .fetch_discard(fetch_discard),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] e_stall, input logic e_flush,
                         input logic [31:0] e_pc, input logic e_fd);
    chk({tag, ".stall"}, {26'd0, stall}, {26'd0, e_stall});
    chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
    chk({tag, ".new_pc"}, new_pc, e_pc);
    chk({tag, ".fetch_discard"}, {31'd0, fetch_discard}, {31'd0, e_fd});
  endtask

  task automatic chk_cnt(input string tag, input int e_cnt);
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, 32'(e_cnt));
  endtask

  // Advance one clock edge, then settle inputs 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype_i = 32'h0; cp0_epc_i = 32'h0; ibus_busy_i = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    chk_out("reset", 6'b000000, 0, 32'h0, 0);
    chk_cnt("reset", 0);
    cyc();
    rst = 1'b0;
    #1;
    chk_out("idle", 6'b000000, 0, 32'h0, 0);

    // Stall priority
    stallreq_id = 1; stallreq_ex = 1; #1;
    chk_out("id_ex", 6'b001111, 0, 32'h0, 0);
    cyc(); chk_cnt("id_ex", 1);
    idle_inputs(); stallreq_if = 1; #1;
    chk_out("if_only", 6'b000011, 0, 32'h0, 0);
    cyc(); chk_cnt("if_only", 2);
    stallreq_id = 1; stallreq_ex = 1; stallreq_mem = 1; #1;
    chk_out("all_req", 6'b011111, 0, 32'h0, 0);
    cyc(); chk_cnt("all_req", 3);
    idle_inputs(); stallreq_id = 1; #1;
    chk_out("id_only", 6'b000111, 0, 32'h0, 0);
    cyc(); chk_cnt("id_only", 4);

    // Plain exception, bus idle: single flush, stay in RUN
    idle_inputs(); excepttype_i = 32'h1; stallreq_if = 1; #1;
    chk_out("exc1", 6'b000000, 1, 32'hBFC00380, 0);
    cyc();
    idle_inputs(); #1;
    chk_out("exc1_after", 6'b000000, 0, 32'h0, 0);
    chk_cnt("exc1_after", 4);

    // eret with fetch outstanding: flush to EPC then 3 drain cycles
    excepttype_i = 32'hE; cp0_epc_i = 32'hBFC00100; ibus_busy_i = 1; #1;
    chk_out("eret", 6'b000000, 1, 32'hBFC00100, 0);
    cyc();
    excepttype_i = 32'h1; stallreq_mem = 1; #1;
    chk_out("drain1", 6'b000011, 0, 32'h0, 1);
    cyc(); chk_cnt("drain1", 5);
    excepttype_i = 32'h0; stallreq_mem = 0; #1;
    chk_out("drain2", 6'b000011, 0, 32'h0, 1);
    cyc();
    ibus_busy_i = 0; #1;
    chk_out("drain3", 6'b000011, 0, 32'h0, 1);
    cyc();
    idle_inputs(); #1;
    chk_out("drain_exit", 6'b000000, 0, 32'h0, 0);
    chk_cnt("drain_exit", 7);

    // Exception deferred behind a MEM stall
    excepttype_i = 32'h4; stallreq_mem = 1; #1;
    chk_out("defer1", 6'b011111, 0, 32'h0, 0);
    cyc();
    chk_out("defer2", 6'b011111, 0, 32'h0, 0);
    cyc(); chk_cnt("defer2", 9);
    stallreq_mem = 0; #1;
    chk_out("defer_go", 6'b000000, 1, 32'hBFC00380, 0);
    cyc();
    idle_inputs(); #1;
    chk_cnt("defer_go", 9);

    // Counter wrap: 6 stalled cycles reach all-ones, one more wraps
    stallreq_if = 1;
    for (int i = 0; i < 6; i++) cyc();
    chk_cnt("cnt_full", 15);
    cyc();
    chk_cnt("cnt_wrap", 0);
    cyc();
    chk_cnt("cnt_after_wrap", 1);
    idle_inputs(); #1;

    // Async reset in the middle of a drain
    excepttype_i = 32'h1; ibus_busy_i = 1; #1;
    chk_out("exc_pre_rst", 6'b000000, 1, 32'hBFC00380, 0);
    cyc();
    excepttype_i = 32'h0; #1;
    chk_out("drain_pre_rst", 6'b000011, 0, 32'h0, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 6'b000000, 0, 32'h0, 0);
    chk_cnt("rst_mid", 0);
    cyc();
    rst = 1'b0; #1;
    chk_out("run_after_rst", 6'b000000, 0, 32'h0, 0);
    cyc();
    chk_out("run_after_rst2", 6'b000000, 0, 32'h0, 0);
    chk_cnt("run_after_rst2", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
